// File: rtl/w4a8_tile_scheduler_if.sv
// Engine-side bundle of the w4a8 tile scheduler: per-engine start/done handshake,
// tile addresses and opcode. The scheduler uses the master modport, the engines the slave.
interface w4a8_tile_scheduler_if #(
   parameter int NUM_ENGINES = 4
);
   logic [NUM_ENGINES-1:0]    eng_start;
   logic [NUM_ENGINES-1:0]    eng_done;
   logic [NUM_ENGINES*64-1:0] eng_addr_act;
   logic [NUM_ENGINES*64-1:0] eng_addr_wgt;
   logic [NUM_ENGINES*64-1:0] eng_addr_res;
   logic [NUM_ENGINES*32-1:0] eng_op_code;

   modport master (
      output eng_start,
      output eng_addr_act,
      output eng_addr_wgt,
      output eng_addr_res,
      output eng_op_code,
      input  eng_done
   );

   modport slave (
      input  eng_start,
      input  eng_addr_act,
      input  eng_addr_wgt,
      input  eng_addr_res,
      input  eng_op_code,
      output eng_done
   );
endinterface

// File: rtl/w4a8_tile_scheduler.sv
// Multi-engine GEMM tile dispatcher: splits M x N into tiles and hands them to free engines.
// Optional perf counters (perf_cycles/perf_tiles) are enabled with `define W4A8_SCHED_PERF_EN.
module w4a8_tile_scheduler #(
   parameter int          NUM_ENGINES    = 4,
   parameter int          TILE_M         = 32,
   parameter int          TILE_N         = 32,
   parameter logic [63:0] ACT_TILE_BYTES = 64'd4096,
   parameter logic [63:0] WGT_TILE_BYTES = 64'd4096,
   parameter logic [63:0] RES_TILE_BYTES = 64'd32768,
   parameter logic [7:0]  MODE           = 8'h01
) (
   input  logic                          ap_clk,
   input  logic                          areset,
   input  logic                          ap_start,
   output logic                          ap_done,
   output logic                          ap_idle,
   input  logic [31:0]                   M,
   input  logic [31:0]                   N,
   input  logic [31:0]                   K,
   input  logic [63:0]                   axi00_ptr0,
   input  logic [63:0]                   axi01_ptr0,
   input  logic [63:0]                   axi02_ptr0,
`ifdef W4A8_SCHED_PERF_EN
   output logic [31:0]                   perf_cycles,
   output logic [31:0]                   perf_tiles,
`endif
   w4a8_tile_scheduler_if.master         eng
);

   localparam int TM_SHIFT = $clog2(TILE_M);
   localparam int TN_SHIFT = $clog2(TILE_N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_DISPATCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                       r_state;
   logic                         r_apDone;
   logic                         r_apIdle;
   logic [NUM_ENGINES-1:0]       r_busy;
   logic [NUM_ENGINES-1:0]       r_engStart;
   logic [NUM_ENGINES-1:0][63:0] r_engAct;
   logic [NUM_ENGINES-1:0][63:0] r_engWgt;
   logic [NUM_ENGINES-1:0][63:0] r_engRes;
   logic [NUM_ENGINES-1:0][31:0] r_engOp;
   logic [31:0]                  r_m;
   logic [31:0]                  r_n;
   logic [23:0]                  r_k;
   logic [31:0]                  r_tm;
   logic [31:0]                  r_tn;
   logic [31:0]                  r_mIdx;
   logic [31:0]                  r_nIdx;
   logic [63:0]                  r_actBase;
   logic [63:0]                  r_actNext;
   logic [63:0]                  r_wgtNext;
   logic [63:0]                  r_resNext;

   logic [31:0]                  w_tmSetup;
   logic [31:0]                  w_tnSetup;
   logic [31:0]                  w_tm;
   logic [31:0]                  w_tn;
   logic [NUM_ENGINES-1:0]       w_freeMask;
   logic                         w_issue;
   logic                         w_lastM;
   logic                         w_lastTile;

   // Tile counts are derived from the latched dimensions while in SETUP, then held in r_tm/r_tn.
   assign w_tmSetup = (r_m + 32'(TILE_M - 1)) >> TM_SHIFT;
   assign w_tnSetup = (r_n + 32'(TILE_N - 1)) >> TN_SHIFT;
   assign w_tm      = (r_state == S_SETUP) ? w_tmSetup : r_tm;
   assign w_tn      = (r_state == S_SETUP) ? w_tnSetup : r_tn;

   // Lowest clear bit of the busy mask, one-hot; all-ones busy wraps to zero, so no engine is free.
   assign w_freeMask = ~r_busy & (r_busy + NUM_ENGINES'(1));

   assign w_issue    = (((r_state == S_SETUP) && (w_tmSetup != 32'd0) && (w_tnSetup != 32'd0)) ||
                        (r_state == S_DISPATCH)) && (|w_freeMask);
   assign w_lastM    = (r_mIdx == w_tm - 32'd1);
   assign w_lastTile = w_lastM && (r_nIdx == w_tn - 32'd1);

   // Control FSM plus the tile walker; running address registers avoid any multipliers.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_state    <= S_IDLE;
         r_apDone   <= 1'b0;
         r_apIdle   <= 1'b1;
         r_busy     <= '0;
         r_engStart <= '0;
         r_engAct   <= '0;
         r_engWgt   <= '0;
         r_engRes   <= '0;
         r_engOp    <= '0;
         r_m        <= '0;
         r_n        <= '0;
         r_k        <= '0;
         r_tm       <= '0;
         r_tn       <= '0;
         r_mIdx     <= '0;
         r_nIdx     <= '0;
         r_actBase  <= '0;
         r_actNext  <= '0;
         r_wgtNext  <= '0;
         r_resNext  <= '0;
      end else begin
         r_apDone   <= 1'b0;
         r_engStart <= '0;
         r_busy     <= (r_busy & ~eng.eng_done) | (w_issue ? w_freeMask : '0);

         if (w_issue) begin
            for (int e = 0; e < NUM_ENGINES; e++) begin
               if (w_freeMask[e]) begin
                  r_engStart[e] <= 1'b1;
                  r_engAct[e]   <= r_actNext;
                  r_engWgt[e]   <= r_wgtNext;
                  r_engRes[e]   <= r_resNext;
                  r_engOp[e]    <= {MODE, r_k};
               end
            end
            r_resNext <= r_resNext + RES_TILE_BYTES;
            if (w_lastM) begin
               r_mIdx    <= '0;
               r_actNext <= r_actBase;
               r_nIdx    <= r_nIdx + 32'd1;
               r_wgtNext <= r_wgtNext + WGT_TILE_BYTES;
            end else begin
               r_mIdx    <= r_mIdx + 32'd1;
               r_actNext <= r_actNext + ACT_TILE_BYTES;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (ap_start) begin
                  r_m       <= M;
                  r_n       <= N;
                  r_k       <= K[23:0];
                  r_mIdx    <= '0;
                  r_nIdx    <= '0;
                  r_actBase <= axi00_ptr0;
                  r_actNext <= axi00_ptr0;
                  r_wgtNext <= axi01_ptr0;
                  r_resNext <= axi02_ptr0;
                  r_apIdle  <= 1'b0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_tm <= w_tmSetup;
               r_tn <= w_tnSetup;
               if ((w_tmSetup == 32'd0) || (w_tnSetup == 32'd0)) begin
                  r_apDone <= 1'b1;
                  r_state  <= S_DONE;
               end else if (w_lastTile) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_state <= S_DISPATCH;
               end
            end
            S_DISPATCH: begin
               if (w_issue && w_lastTile) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_busy == '0) begin
                  r_apDone <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_apIdle <= 1'b1;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ap_done          = r_apDone;
   assign ap_idle          = r_apIdle;
   assign eng.eng_start    = r_engStart;
   assign eng.eng_addr_act = r_engAct;
   assign eng.eng_addr_wgt = r_engWgt;
   assign eng.eng_addr_res = r_engRes;
   assign eng.eng_op_code  = r_engOp;

`ifdef W4A8_SCHED_PERF_EN
   logic [31:0] r_perfCycles;
   logic [31:0] r_perfTiles;

   // The accepted start cycle counts as the first cycle; counting stops once back in IDLE.
   always_ff @(posedge ap_clk) begin
      if (areset) begin
         r_perfCycles <= '0;
         r_perfTiles  <= '0;
      end else if ((r_state == S_IDLE) && ap_start) begin
         r_perfCycles <= 32'd1;
         r_perfTiles  <= '0;
      end else begin
         if ((r_state != S_IDLE) && (r_perfCycles != 32'hFFFF_FFFF)) begin
            r_perfCycles <= r_perfCycles + 32'd1;
         end
         if (w_issue) begin
            r_perfTiles <= r_perfTiles + 32'd1;
         end
      end
   end

   assign perf_cycles = r_perfCycles;
   assign perf_tiles  = r_perfTiles;
`endif

endmodule

// File: tb/tb_w4a8_tile_scheduler.sv
// Self-checking bench for w4a8_tile_scheduler: directed and randomized jobs against a
// cycle-level model of tile issue order, engine availability and completion timing.
module tb_w4a8_tile_scheduler;

   localparam int NE     = 4;
   localparam int TM     = 32;
   localparam int TN     = 32;
   localparam int ACT_B  = 4096;
   localparam int WGT_B  = 4096;
   localparam int RES_B  = 32768;

   logic        clk;
   logic        areset;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic [31:0] M;
   logic [31:0] N;
   logic [31:0] K;
   logic [63:0] p0;
   logic [63:0] p1;
   logic [63:0] p2;
`ifdef W4A8_SCHED_PERF_EN
   logic [31:0] perfCycles;
   logic [31:0] perfTiles;
`endif

   int testsRun;
   int testsFailed;

   int          availAt [NE];
   int          doneAt  [NE];
   logic [63:0] expAct  [NE];
   logic [63:0] expWgt  [NE];
   logic [63:0] expRes  [NE];
   logic [31:0] expOp   [NE];

   w4a8_tile_scheduler_if #(.NUM_ENGINES(NE)) engIf ();

   w4a8_tile_scheduler #(.NUM_ENGINES(NE)) dut (
      .ap_clk     (clk),
      .areset     (areset),
      .ap_start   (ap_start),
      .ap_done    (ap_done),
      .ap_idle    (ap_idle),
      .M          (M),
      .N          (N),
      .K          (K),
      .axi00_ptr0 (p0),
      .axi01_ptr0 (p1),
      .axi02_ptr0 (p2),
`ifdef W4A8_SCHED_PERF_EN
      .perf_cycles(perfCycles),
      .perf_tiles (perfTiles),
`endif
      .eng        (engIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then advance to just after the next rising edge.
   task automatic applyStimulus(input logic start, input logic [NE-1:0] done, input logic rst);
      ap_start         = start;
      engIf.eng_done   = done;
      areset           = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkEngines(input string tag);
      for (int e = 0; e < NE; e++) begin
         checkOutput($sformatf("%s_act%0d", tag, e), engIf.eng_addr_act[e*64 +: 64], expAct[e]);
         checkOutput($sformatf("%s_wgt%0d", tag, e), engIf.eng_addr_wgt[e*64 +: 64], expWgt[e]);
         checkOutput($sformatf("%s_res%0d", tag, e), engIf.eng_addr_res[e*64 +: 64], expRes[e]);
         checkOutput($sformatf("%s_op%0d", tag, e), 64'(engIf.eng_op_code[e*32 +: 32]), 64'(expOp[e]));
      end
   endtask

   task automatic clearModel();
      for (int e = 0; e < NE; e++) begin
         availAt[e] = 0;
         doneAt[e]  = -1;
         expAct[e]  = '0;
         expWgt[e]  = '0;
         expRes[e]  = '0;
         expOp[e]   = '0;
      end
   endtask

   // latMode: 0 random 0..5, 1 higher engines finish first, 2 long fixed latency.
   task automatic runJob(input logic [31:0] m, input logic [31:0] n, input logic [31:0] k,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                         input int latMode, input bit pulseDrain, input int resetAt);
      logic [31:0]    tm;
      logic [31:0]    tn;
      logic [NE-1:0]  expStart;
      logic [NE-1:0]  doneVec;
      int             total;
      int             tileIdx;
      int             c;
      int             lastDone;
      int             lastIssue;
      int             expDone;
      int             sel;
      int             mi;
      int             ni;
      int             lat;
      bit             finished;

      tm        = (m + 32'(TM - 1)) / 32'(TM);
      tn        = (n + 32'(TN - 1)) / 32'(TN);
      total     = int'(tm * tn);
      tileIdx   = 0;
      lastDone  = 0;
      lastIssue = -1;
      expDone   = ((tm == 0) || (tn == 0)) ? 2 : -1;
      finished  = 1'b0;
      for (int e = 0; e < NE; e++) begin
         availAt[e] = 2;
         doneAt[e]  = -1;
      end

      M  = m;
      N  = n;
      K  = k;
      p0 = a;
      p1 = b;
      p2 = r;
      applyStimulus(1'b1, '0, 1'b0);
      c = 1;

      while (!finished && c < 3000) begin
         expStart = '0;
         if (c >= 2 && tileIdx < total) begin
            sel = -1;
            for (int i = 0; i < NE; i++) begin
               if (sel < 0 && availAt[i] <= c) sel = i;
            end
            if (sel >= 0) begin
               mi             = tileIdx % int'(tm);
               ni             = tileIdx / int'(tm);
               expStart[sel]  = 1'b1;
               expAct[sel]    = a + 64'(mi) * 64'(ACT_B);
               expWgt[sel]    = b + 64'(ni) * 64'(WGT_B);
               expRes[sel]    = r + 64'(tileIdx) * 64'(RES_B);
               expOp[sel]     = {8'h01, k[23:0]};
               case (latMode)
                  0:       lat = int'($urandom_range(0, 5));
                  1:       lat = 2 * (NE - 1 - sel) + 1;
                  default: lat = 12;
               endcase
               doneAt[sel]  = c + lat;
               availAt[sel] = c + lat + 2;
               if (c + lat > lastDone) lastDone = c + lat;
               tileIdx++;
               if (tileIdx == total) begin
                  lastIssue = c;
                  expDone   = lastDone + 2;
               end
            end
         end

         checkOutput($sformatf("start_c%0d", c), 64'(engIf.eng_start), 64'(expStart));
         checkOutput($sformatf("done_c%0d", c), 64'(ap_done), 64'(expDone == c));
         checkOutput($sformatf("idle_c%0d", c), 64'(ap_idle), 64'(expDone >= 0 && c > expDone));
         checkEngines($sformatf("c%0d", c));

         if (expDone >= 0 && c == expDone + 1) begin
            finished = 1'b1;
         end else if (c == resetAt) begin
            applyStimulus(1'b0, '0, 1'b1);
            doneVec = '0;
            if (doneAt[0] >= c) doneVec[0] = 1'b1;
            clearModel();
            checkOutput("rst_idle", 64'(ap_idle), 64'd1);
            checkOutput("rst_done", 64'(ap_done), 64'd0);
            checkOutput("rst_start", 64'(engIf.eng_start), 64'd0);
            checkEngines("rst");
            applyStimulus(1'b0, doneVec, 1'b0);
            checkOutput("stale_done_idle", 64'(ap_idle), 64'd1);
            checkOutput("stale_done_start", 64'(engIf.eng_start), 64'd0);
            return;
         end else begin
            doneVec = '0;
            for (int e = 0; e < NE; e++) begin
               if (doneAt[e] == c) doneVec[e] = 1'b1;
               else if (doneAt[e] < c && $urandom_range(0, 7) == 0) doneVec[e] = 1'b1;
            end
            applyStimulus(pulseDrain && (c == lastIssue), doneVec, 1'b0);
            c++;
         end
      end
      checkOutput("job_completed", 64'(finished), 64'd1);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, '0, 1'b0);
         checkOutput("post_done", 64'(ap_done), 64'd0);
         checkOutput("post_idle", 64'(ap_idle), 64'd1);
         checkOutput("post_start", 64'(engIf.eng_start), 64'd0);
      end
`ifdef W4A8_SCHED_PERF_EN
      checkOutput("perf_tiles", 64'(perfTiles), 64'(total));
      checkOutput("perf_cycles", 64'(perfCycles), 64'(expDone + 1));
`endif
   endtask

   initial begin
      testsRun       = 0;
      testsFailed    = 0;
      ap_start       = 1'b0;
      engIf.eng_done = '0;
      areset         = 1'b1;
      M  = '0;
      N  = '0;
      K  = '0;
      p0 = '0;
      p1 = '0;
      p2 = '0;
      clearModel();

      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("reset_idle", 64'(ap_idle), 64'd1);
      checkOutput("reset_done", 64'(ap_done), 64'd0);
      checkOutput("reset_start", 64'(engIf.eng_start), 64'd0);
      checkEngines("reset");
`ifdef W4A8_SCHED_PERF_EN
      checkOutput("reset_perf_cycles", 64'(perfCycles), 64'd0);
      checkOutput("reset_perf_tiles", 64'(perfTiles), 64'd0);
`endif

      applyStimulus(1'b0, '1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("spurious_idle", 64'(ap_idle), 64'd1);
      checkOutput("spurious_start", 64'(engIf.eng_start), 64'd0);

      runJob(32'd64, 32'd64, 32'd4096, 64'h1000, 64'h2000, 64'h3000, 1, 1'b0, -1);
      checkOutput("eng3_act", engIf.eng_addr_act[3*64 +: 64], 64'h2000);
      checkOutput("eng3_wgt", engIf.eng_addr_wgt[3*64 +: 64], 64'h3000);
      checkOutput("eng3_res", engIf.eng_addr_res[3*64 +: 64], 64'h3000 + 64'd3 * 64'd32768);
      checkOutput("eng3_op", 64'(engIf.eng_op_code[3*32 +: 32]), 64'h0100_1000);

      runJob(32'd100, 32'd32, 32'h00AB_CDEF, 64'h10_0000, 64'h20_0000, 64'h30_0000, 1, 1'b0, -1);
      runJob(32'd0, 32'd64, 32'd16, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
      runJob(32'd64, 32'd0, 32'd16, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
      runJob(32'hFFFF_FFF0, 32'd64, 32'd16, 64'h1000, 64'h2000, 64'h3000, 0, 1'b0, -1);
      runJob(32'd32, 32'd33, 32'hFF12_3456, 64'h4000, 64'h5000, 64'h6000, 0, 1'b0, -1);
      runJob(32'd64, 32'd64, 32'd4096, 64'h1000, 64'h2000, 64'h3000, 2, 1'b0, 4);
      runJob(32'd64, 32'd64, 32'd4096, 64'h7000, 64'h8000, 64'h9000, 0, 1'b0, -1);
      runJob(32'd64, 32'd96, 32'd512, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_E000,
             64'hFFFF_FFFF_FFFF_0000, 0, 1'b1, -1);

      for (int j = 0; j < 10; j++) begin
         runJob(32'($urandom_range(0, 230)), 32'($urandom_range(0, 230)), $urandom,
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                0, 1'($urandom_range(0, 1)), -1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
